// File: rtl/e10_ti_param.sv
// Six-state Moore controller with data capture register and a counter-armed
// output payload (zero / invert / freeze), parametrised for benchmark reuse.
module e10_ti_param #(
   parameter int         NX          = 10,
   parameter int         NY          = 13,
   parameter int         CNT_W       = 4,
   parameter int         THRESH      = 5,
   parameter int         MODE        = 0,
   parameter logic [5:0] TRIG_STATES = 6'b000100,
   parameter bit         STICKY      = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NX-1:0] x,
   output logic [NY-1:0] y,
   output logic [2:0]    state_o,
   output logic          trig_o
);

   localparam int DW = NY - 6;
   localparam int XW = NX - 5;
   localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      RUN  = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t           state, state_nx;
   logic [DW-1:0]    d, d_load;
   logic [CNT_W-1:0] cnt;
   logic [NY-1:0]    yh, y_nom;
   logic [5:0]       onehot;
   logic [7:0]       trig_mask;
   logic             cnt_en;

   // Data field is zero-extended or LSB-truncated to fit the output slice.
   if (XW >= DW) begin : g_trunc
      assign d_load = x[5 +: DW];
   end else begin : g_zext
      assign d_load = {{(DW-XW){1'b0}}, x[NX-1:5]};
   end

   assign trig_mask = {2'b00, TRIG_STATES};
   assign cnt_en    = trig_mask[state] & x[4];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      state_nx = IDLE;
      onehot   = '0;
      case (state)
         IDLE: begin
            onehot[0] = 1'b1;
            state_nx  = x[0] ? ARM : IDLE;
         end
         ARM: begin
            onehot[1] = 1'b1;
            if (x[3])      state_nx = ERR;
            else if (x[1]) state_nx = IDLE;
            else           state_nx = RUN;
         end
         RUN: begin
            onehot[2] = 1'b1;
            if (x[3])      state_nx = ERR;
            else if (x[1]) state_nx = DONE;
            else if (x[2]) state_nx = HOLD;
            else           state_nx = RUN;
         end
         HOLD: begin
            onehot[3] = 1'b1;
            if (x[3])       state_nx = ERR;
            else if (!x[2]) state_nx = RUN;
            else            state_nx = HOLD;
         end
         DONE: begin
            onehot[4] = 1'b1;
            state_nx  = x[0] ? ARM : IDLE;
         end
         ERR: begin
            onehot[5] = 1'b1;
            state_nx  = (x[1] && !x[3]) ? IDLE : ERR;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign y_nom   = {d, onehot};
   assign trig_o  = (cnt == THR);
   assign state_o = state;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (!rst) begin
         state <= IDLE;
         d     <= '0;
         cnt   <= '0;
         yh    <= '0;
      end else begin
         state <= state_nx;
         if (state == RUN) d <= d_load;
         if (!STICKY && state == IDLE) cnt <= '0;
         else if (cnt_en && cnt != THR) cnt <= cnt + 1'b1;
         if (!trig_o) yh <= y_nom;
      end
   end

   // Payload only reshapes the visible output; control and data paths are untouched.
   always_comb begin
      y = y_nom;
      if (trig_o) begin
         case (MODE)
            0:       y = '0;
            1:       y = ~y_nom;
            default: y = yh;
         endcase
      end
   end

endmodule

// File: tb/tb_e10_ti_param.sv
// Directed bench for e10_ti_param: four instances share stimulus and differ
// only in payload mode / stickiness, so one sequence exercises every variant.
module tb_e10_ti_param;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  x   = '0;

   logic [12:0] y0, y1, y2, y3;
   logic [2:0]  s0, s1, s2, s3;
   logic        t0, t1, t2, t3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   e10_ti_param #(.MODE(0), .STICKY(1'b1)) u_zero (
      .clk(clk), .rst(rst), .x(x), .y(y0), .state_o(s0), .trig_o(t0));
   e10_ti_param #(.MODE(1), .STICKY(1'b1)) u_inv (
      .clk(clk), .rst(rst), .x(x), .y(y1), .state_o(s1), .trig_o(t1));
   e10_ti_param #(.MODE(2), .STICKY(1'b1)) u_frz (
      .clk(clk), .rst(rst), .x(x), .y(y2), .state_o(s2), .trig_o(t2));
   e10_ti_param #(.MODE(0), .STICKY(1'b0)) u_nst (
      .clk(clk), .rst(rst), .x(x), .y(y3), .state_o(s3), .trig_o(t3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 ns after the rising edge.
   task automatic step(input logic [9:0] xv);
      @(negedge clk);
      x = xv;
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle asynchronous assert, immediate check, release on a falling edge.
   task automatic do_reset(input string tag);
      #3;
      x   = '0;
      rst = 1'b0;
      #1;
      check({tag, "_y"},    32'(y0), 32'h0001);
      check({tag, "_st"},   32'(s0), 32'd0);
      check({tag, "_trig"}, 32'(t0), 32'd0);
      check({tag, "_ynst"}, 32'(y3), 32'h0001);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("por_y", 32'(y0), 32'h0001);
      check("por_trig_inv", 32'(t1), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Nominal path with data capture and HOLD excursion
      step(10'h001); check("a_arm", 32'(s0), 32'd1);
      step(10'h2C0); check("a_run_y", 32'(y0), 32'h0004);
      step(10'h2C0); check("a_run_d", 32'(y0), 32'h0584);
      step(10'h2C4); check("a_hold", 32'(y0), 32'h0588);
      step(10'h2C4); check("a_hold2", 32'(s0), 32'd3);
      step(10'h2C0); check("a_back_run", 32'(y0), 32'h0584);
      step(10'h2C2); check("a_done", 32'(y0), 32'h0590);
      step(10'h000); check("a_idle", 32'(y0), 32'h0581);

      // Trigger with d=0 in RUN
      do_reset("b_rst");
      step(10'h001);
      step(10'h000); check("b_run", 32'(s0), 32'd2);
      repeat (4) step(10'h010);
      check("b_cnt4_trig", 32'(t0), 32'd0);
      check("b_cnt4_y", 32'(y0), 32'h0004);
      step(10'h010);
      check("b_trig", 32'(t0), 32'd1);
      check("b_zero_y", 32'(y0), 32'h0000);
      check("b_inv_y", 32'(y1), 32'h1FFB);
      check("b_frz_y", 32'(y2), 32'h0004);
      step(10'h002);
      check("b_done_st", 32'(s0), 32'd4);
      check("b_done_zero", 32'(y0), 32'h0000);
      check("b_done_inv", 32'(y1), 32'h1FEF);
      check("b_done_frz", 32'(y2), 32'h0004);
      step(10'h000);
      check("b_idle_nst_trig", 32'(t3), 32'd1);
      check("b_idle_nst_y", 32'(y3), 32'h0000);
      step(10'h000);
      check("b_clr_nst_trig", 32'(t3), 32'd0);
      check("b_clr_nst_y", 32'(y3), 32'h0001);
      check("b_sticky_trig", 32'(t0), 32'd1);
      check("b_sticky_inv", 32'(y1), 32'h1FFE);
      check("b_sticky_frz", 32'(y2), 32'h0004);

      // Partial count survives an ERR excursion, then completes
      do_reset("c_rst");
      step(10'h001);
      step(10'h000);
      repeat (4) step(10'h010);
      step(10'h008); check("c_err", 32'(s0), 32'd5);
      step(10'h00A); check("c_err_stay", 32'(s0), 32'd5);
      check("c_err_trig", 32'(t0), 32'd0);
      step(10'h002); check("c_idle", 32'(s0), 32'd0);
      step(10'h001);
      step(10'h000); check("c_rerun_trig", 32'(t0), 32'd0);
      step(10'h010);
      check("c_trig", 32'(t0), 32'd1);
      check("c_nst_notrig", 32'(t3), 32'd0);
      repeat (11) step(10'h010);
      check("c_sat_trig", 32'(t0), 32'd1);
      check("c_sat_y", 32'(y0), 32'h0000);
      check("c_nst_sat_trig", 32'(t3), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
